// File: rtl/id_exe.sv
// ============================================================================
// Module  : id_exe
// Purpose : Decode-to-execute pipeline register with stall hold, bubble
//           insertion and load-hazard feedback. Optional perf counters are
//           built when ID_EXE_PERF_EN is defined.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module id_exe #(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int RADDR_WIDTH    = 5,
    parameter int CSR_ADDR_WIDTH = 12,
    parameter int CNT_WIDTH      = 32
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic [5:0]                stall_i,
    input  logic                      flush_i,
    input  logic [DATA_WIDTH-1:0]     inst_i,
    input  logic [ADDR_WIDTH-1:0]     inst_addr_i,
    input  logic [DATA_WIDTH-1:0]     op1_i,
    input  logic [DATA_WIDTH-1:0]     op2_i,
    input  logic                      reg_we_i,
    input  logic [RADDR_WIDTH-1:0]    reg_waddr_i,
    input  logic                      csr_we_i,
    input  logic [CSR_ADDR_WIDTH-1:0] csr_addr_i,
    output logic [DATA_WIDTH-1:0]     inst_o,
    output logic [ADDR_WIDTH-1:0]     inst_addr_o,
    output logic [DATA_WIDTH-1:0]     op1_o,
    output logic [DATA_WIDTH-1:0]     op2_o,
    output logic                      reg_we_o,
    output logic [RADDR_WIDTH-1:0]    reg_waddr_o,
    output logic                      csr_we_o,
    output logic [CSR_ADDR_WIDTH-1:0] csr_addr_o,
    output logic                      valid_o,
    output logic [RADDR_WIDTH-1:0]    exe_rd_o,
    output logic                      pre_inst_is_load_o,
    output logic [CNT_WIDTH-1:0]      bubble_cnt_o,
    output logic [CNT_WIDTH-1:0]      flush_cnt_o
);

    localparam logic [DATA_WIDTH-1:0] c_NOP         = DATA_WIDTH'(32'h0000_0013);
    localparam logic [6:0]            c_INST_TYPE_L = 7'b000_0011;

    logic [DATA_WIDTH-1:0]     r_inst;
    logic [ADDR_WIDTH-1:0]     r_inst_addr;
    logic [DATA_WIDTH-1:0]     r_op1;
    logic [DATA_WIDTH-1:0]     r_op2;
    logic                      r_reg_we;
    logic [RADDR_WIDTH-1:0]    r_reg_waddr;
    logic                      r_csr_we;
    logic [CSR_ADDR_WIDTH-1:0] r_csr_addr;
    logic                      r_valid;

    logic w_exe_stall;
    logic w_id_stall;
    logic w_insert_bubble;

    assign w_exe_stall     = stall_i[3];
    assign w_id_stall      = stall_i[2];
    assign w_insert_bubble = flush_i | w_id_stall;

    // Only the id/exe bits of the ctrl stall vector matter to this stage.
    logic w_unused_stall;
    assign w_unused_stall = ^{stall_i[5:4], stall_i[1:0]};

    always_ff @(posedge clk_i) begin
        if (rst_i || (!w_exe_stall && w_insert_bubble)) begin
            r_inst      <= c_NOP;
            r_inst_addr <= '0;
            r_op1       <= '0;
            r_op2       <= '0;
            r_reg_we    <= 1'b0;
            r_reg_waddr <= '0;
            r_csr_we    <= 1'b0;
            r_csr_addr  <= '0;
            r_valid     <= 1'b0;
        end else if (!w_exe_stall) begin
            r_inst      <= inst_i;
            r_inst_addr <= inst_addr_i;
            r_op1       <= op1_i;
            r_op2       <= op2_i;
            r_reg_we    <= reg_we_i;
            r_reg_waddr <= reg_waddr_i;
            r_csr_we    <= csr_we_i;
            r_csr_addr  <= csr_addr_i;
            r_valid     <= (inst_i != c_NOP);
        end
    end

    assign inst_o      = r_inst;
    assign inst_addr_o = r_inst_addr;
    assign op1_o       = r_op1;
    assign op2_o       = r_op2;
    assign reg_we_o    = r_reg_we;
    assign reg_waddr_o = r_reg_waddr;
    assign csr_we_o    = r_csr_we;
    assign csr_addr_o  = r_csr_addr;
    assign valid_o     = r_valid;

    // Hazard feedback to id is derived purely from the registered slot.
    assign exe_rd_o           = r_reg_we ? r_reg_waddr : '0;
    assign pre_inst_is_load_o = r_valid && (r_inst[6:0] == c_INST_TYPE_L);

`ifdef ID_EXE_PERF_EN
    logic [CNT_WIDTH-1:0] r_bubble_cnt;
    logic [CNT_WIDTH-1:0] r_flush_cnt;

    // Flush outranks the decode stall, so an edge counts in at most one counter.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_bubble_cnt <= '0;
            r_flush_cnt  <= '0;
        end else if (!w_exe_stall) begin
            if (flush_i) begin
                if (r_flush_cnt != '1) r_flush_cnt <= r_flush_cnt + CNT_WIDTH'(1);
            end else if (w_id_stall) begin
                if (r_bubble_cnt != '1) r_bubble_cnt <= r_bubble_cnt + CNT_WIDTH'(1);
            end
        end
    end

    assign bubble_cnt_o = r_bubble_cnt;
    assign flush_cnt_o  = r_flush_cnt;
`else
    assign bubble_cnt_o = '0;
    assign flush_cnt_o  = '0;
`endif

endmodule

`default_nettype wire
